// File: rtl/divider_4b_seq_if.sv
// Start/busy/done handshake and operand/result bus between the ALU controller
// (master) and the sequential divider (slave).
interface divider_4b_seq_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/divider_4b_seq.sv
// Unsigned restoring divider: one shift-and-trial-subtract step per clock,
// results registered on entry to DONE and held until the next completed op.
module divider_4b_seq #(
   parameter int WIDTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   divider_4b_seq_if.slave  divBus
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic [WIDTH:0]   r_p;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_div;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;
   logic             r_dbz;

   logic [WIDTH:0]   w_pShift;
   logic [WIDTH:0]   w_trial;
   logic [WIDTH:0]   w_pNext;
   logic [WIDTH-1:0] w_qNext;
   logic             w_lastIter;

   // A negative trial result (MSB set) means the subtract is undone and a 0
   // quotient bit is shifted in.
   always_comb begin
      w_pShift   = {r_p[WIDTH-1:0], r_q[WIDTH-1]};
      w_trial    = w_pShift - {1'b0, r_div};
      w_pNext    = w_trial[WIDTH] ? w_pShift : w_trial;
      w_qNext    = {r_q[WIDTH-2:0], ~w_trial[WIDTH]};
      w_lastIter = (r_count == LAST_ITER);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (divBus.start) begin
               w_nextState = (divBus.divisor == '0) ? DONE : CALC;
            end
         end
         CALC: begin
            if (w_lastIter) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Result registers are only written on the edge that enters DONE.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_p         <= '0;
         r_q         <= '0;
         r_div       <= '0;
         r_count     <= '0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_dbz       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (divBus.start) begin
                  r_p     <= '0;
                  r_q     <= divBus.dividend;
                  r_div   <= divBus.divisor;
                  r_count <= '0;
                  if (divBus.divisor == '0) begin
                     r_quotient  <= '1;
                     r_remainder <= divBus.dividend;
                     r_dbz       <= 1'b1;
                  end
               end
            end
            CALC: begin
               r_p     <= w_pNext;
               r_q     <= w_qNext;
               r_count <= r_count + 1'b1;
               if (w_lastIter) begin
                  r_quotient  <= w_qNext;
                  r_remainder <= w_pNext[WIDTH-1:0];
                  r_dbz       <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign divBus.busy        = (r_state != IDLE);
   assign divBus.done        = (r_state == DONE);
   assign divBus.quotient    = r_quotient;
   assign divBus.remainder   = r_remainder;
   assign divBus.div_by_zero = r_dbz;
endmodule
